aes_round_sequencer: RTL

Iterative AES encryption round controller. Holds the 128-bit cipher state and sequences one round per clock through an external combinational round datapath: SubBytes, ShiftRows, the team's MixColumn block and AddRoundKey. It also indexes an external round-key store. It sits between the plaintext source and the ciphertext sink, and owns the round counter, the last-round MixColumn bypass and both valid/ready handshakes.

---
 rtl/aes_round_sequencer_if.sv | 20 ++
 rtl/aes_round_sequencer.sv | 110 +++++++++++
 2 files changed

// File: rtl/aes_round_sequencer_if.sv
// Plaintext-in / ciphertext-out valid/ready channels of the AES round sequencer.
// The sequencer takes the slave side; the plaintext source / ciphertext sink take master.
interface aes_round_sequencer_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES round controller: owns the cipher state, round counter and both handshakes,
// and drives one round per clock through an external combinational round datapath.
module aes_round_sequencer #(
  parameter int NR = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  abort,
  aes_round_sequencer_if.slave  io,
  output logic                  busy,
  output logic [3:0]            rk_idx,
  input  logic [127:0]          rk_data,
  output logic [127:0]          rf_state,
  output logic                  rf_last,
  input  logic [127:0]          rf_result
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  localparam logic [3:0] LAST = 4'(NR);

  fsm_t         fsm;
  logic [127:0] state;
  logic [3:0]   round;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         busy_q;
  logic         rf_last_q;
  logic [3:0]   rk_idx_q;

  // Handshake, key index and last-round flags are registered alongside fsm so that
  // nothing downstream sees a combinational path from in_valid or out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm         <= IDLE;
      state       <= '0;
      round       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rf_last_q   <= 1'b0;
      rk_idx_q    <= '0;
    end else if (abort) begin
      // state is deliberately held; only control returns to idle
      fsm         <= IDLE;
      round       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rf_last_q   <= 1'b0;
      rk_idx_q    <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (io.in_valid) begin
            state      <= io.in_data ^ rk_data;
            round      <= 4'd1;
            fsm        <= ROUND;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            rk_idx_q   <= 4'd1;
            rf_last_q  <= (LAST == 4'd1);
          end
        end
        ROUND: begin
          state <= rf_result;
          if (round == LAST) begin
            fsm         <= DONE;
            out_valid_q <= 1'b1;
            rf_last_q   <= 1'b0;
            rk_idx_q    <= '0;
          end else begin
            round     <= round + 4'd1;
            rk_idx_q  <= round + 4'd1;
            rf_last_q <= ((round + 4'd1) == LAST);
          end
        end
        DONE: begin
          if (io.out_ready) begin
            fsm         <= IDLE;
            round       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          fsm         <= IDLE;
          round       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          rf_last_q   <= 1'b0;
          rk_idx_q    <= '0;
        end
      endcase
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_data  = state;
  assign busy         = busy_q;
  assign rk_idx       = rk_idx_q;
  assign rf_state     = state;
  assign rf_last      = rf_last_q;

  a_round_bound: assert property (@(posedge clk) disable iff (rst) round <= LAST);
  a_flags_match_fsm: assert property (@(posedge clk) disable iff (rst)
    (in_ready_q == (fsm == IDLE)) && (out_valid_q == (fsm == DONE)) && (busy_q == (fsm != IDLE)));
endmodule
